// File: rtl/dm_store_buffer.sv
// Posted-write store buffer: circular FIFO of aligned stores drained to memory over req/ack,
// with a load hazard check. Define WB_FORWARD_EN to forward pending bytes instead of stalling loads.
module dm_store_buffer #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        st_valid,
    input  logic [31:0] st_addr,
    input  logic [3:0]  st_byteen,
    input  logic [31:0] st_wdata,
    output logic        st_stall,
    input  logic        ld_valid,
    input  logic [31:0] ld_addr,
    output logic        ld_stall,
    output logic [3:0]  ld_fwd_mask,
    output logic [31:0] ld_fwd_data,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_byteen,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    output logic        empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [29:0]      entry_addr_r   [DEPTH];
    logic [3:0]       entry_byteen_r [DEPTH];
    logic [31:0]      entry_wdata_r  [DEPTH];
    logic [DEPTH-1:0] entry_vld_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [PTR_W-1:0] wr_ptr_r;
    logic [CNT_W-1:0] count_r;

    logic             full_s;
    logic             push_s;
    logic             pop_s;
    logic [DEPTH-1:0] match_s;
    logic             unused_s;

    // Word-offset bits are irrelevant to both the queue and the hazard check.
    assign unused_s = ^{st_addr[1:0], ld_addr[1:0]};

    assign full_s   = (count_r == CNT_W'(DEPTH));
    assign push_s   = st_valid & ~full_s & (st_byteen != 4'b0000);
    assign pop_s    = mem_req & mem_ack;

    assign st_stall   = st_valid & full_s;
    assign empty      = (count_r == CNT_W'(0));
    assign mem_req    = (count_r != CNT_W'(0));
    assign mem_addr   = {entry_addr_r[rd_ptr_r], 2'b00};
    assign mem_byteen = entry_byteen_r[rd_ptr_r];
    assign mem_wdata  = entry_wdata_r[rd_ptr_r];

    // Pointer and occupancy bookkeeping; push and pop together leave count unchanged.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr_r <= PTR_W'(0);
            wr_ptr_r <= PTR_W'(0);
            count_r  <= CNT_W'(0);
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Entry storage; contents are cleared on reset so the memory-side outputs read as zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                entry_addr_r[i]   <= 30'b0;
                entry_byteen_r[i] <= 4'b0000;
                entry_wdata_r[i]  <= 32'b0;
            end
            entry_vld_r <= '0;
        end else begin
            if (push_s) begin
                entry_addr_r[wr_ptr_r]   <= st_addr[31:2];
                entry_byteen_r[wr_ptr_r] <= st_byteen;
                entry_wdata_r[wr_ptr_r]  <= st_wdata;
                entry_vld_r[wr_ptr_r]    <= 1'b1;
            end
            // Push and pop never target the same slot: push needs count<DEPTH, pop needs count>0.
            if (pop_s) begin
                entry_vld_r[rd_ptr_r] <= 1'b0;
            end
        end
    end

    // Per-entry word match against the load address, using registered entries only.
    always_comb begin
        match_s = '0;
        for (int i = 0; i < DEPTH; i++) begin
            match_s[i] = entry_vld_r[i] & (entry_addr_r[i] == ld_addr[31:2]);
        end
    end

`ifdef WB_FORWARD_EN
    logic [3:0]  fwd_mask_s;
    logic [31:0] fwd_data_s;

    // Walk oldest to newest so the newest matching entry owns each lane.
    always_comb begin : fwd_merge
        logic [PTR_W-1:0] idx;
        logic             hit;
        fwd_mask_s = 4'b0000;
        fwd_data_s = 32'b0;
        idx        = rd_ptr_r;
        hit        = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = rd_ptr_r + PTR_W'(k);
            for (int b = 0; b < 4; b++) begin
                hit                 = match_s[idx] & entry_byteen_r[idx][b];
                fwd_mask_s[b]       = fwd_mask_s[b] | hit;
                fwd_data_s[8*b +: 8] = hit ? entry_wdata_r[idx][8*b +: 8] : fwd_data_s[8*b +: 8];
            end
        end
    end

    assign ld_stall    = ld_valid & 1'b0;
    assign ld_fwd_mask = fwd_mask_s;
    assign ld_fwd_data = fwd_data_s;
`else
    assign ld_stall    = ld_valid & (|match_s);
    assign ld_fwd_mask = 4'b0000;
    assign ld_fwd_data = 32'b0;
`endif

endmodule

// File: tb/tb_dm_store_buffer.sv
// Self-checking bench for dm_store_buffer: directed scenarios plus randomized traffic
// compared each cycle against a queue-based reference model.
module tb_dm_store_buffer;

    localparam int DEPTH = 4;

    logic        clk;
    logic        reset;
    logic        st_valid;
    logic [31:0] st_addr;
    logic [3:0]  st_byteen;
    logic [31:0] st_wdata;
    logic        st_stall;
    logic        ld_valid;
    logic [31:0] ld_addr;
    logic        ld_stall;
    logic [3:0]  ld_fwd_mask;
    logic [31:0] ld_fwd_data;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [3:0]  mem_byteen;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic        empty;

    typedef struct packed {
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] data;
    } ent_t;

    ent_t q[$];
    int   err_cnt;
    int   chk_cnt;

    dm_store_buffer #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .st_valid   (st_valid),
        .st_addr    (st_addr),
        .st_byteen  (st_byteen),
        .st_wdata   (st_wdata),
        .st_stall   (st_stall),
        .ld_valid   (ld_valid),
        .ld_addr    (ld_addr),
        .ld_stall   (ld_stall),
        .ld_fwd_mask(ld_fwd_mask),
        .ld_fwd_data(ld_fwd_data),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_byteen (mem_byteen),
        .mem_wdata  (mem_wdata),
        .mem_ack    (mem_ack),
        .empty      (empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference forwarding: scan pending stores oldest to newest, later ones override lanes.
    function automatic void model_fwd(input logic [31:0] a, output logic [3:0] m,
                                      output logic [31:0] d, output logic hit);
        m   = 4'b0000;
        d   = 32'b0;
        hit = 1'b0;
        foreach (q[i]) begin
            if (q[i].addr[31:2] == a[31:2]) begin
                hit = 1'b1;
                for (int b = 0; b < 4; b++) begin
                    if (q[i].be[b]) begin
                        m[b]       = 1'b1;
                        d[8*b +: 8] = q[i].data[8*b +: 8];
                    end
                end
            end
        end
    endfunction

    task automatic check_outputs();
        logic [3:0]  em;
        logic [31:0] ed;
        logic        hit;
        check_eq("mem_req", {31'b0, mem_req}, {31'b0, q.size() != 0});
        check_eq("empty", {31'b0, empty}, {31'b0, q.size() == 0});
        check_eq("st_stall", {31'b0, st_stall}, {31'b0, st_valid && (q.size() == DEPTH)});
        if (q.size() != 0) begin
            check_eq("mem_addr", mem_addr, q[0].addr);
            check_eq("mem_byteen", {28'b0, mem_byteen}, {28'b0, q[0].be});
            check_eq("mem_wdata", mem_wdata, q[0].data);
        end
        model_fwd(ld_addr, em, ed, hit);
`ifdef WB_FORWARD_EN
        check_eq("ld_stall", {31'b0, ld_stall}, 32'b0);
        check_eq("fwd_mask", {28'b0, ld_fwd_mask}, {28'b0, em});
        check_eq("fwd_data", ld_fwd_data, ed);
`else
        check_eq("ld_stall", {31'b0, ld_stall}, {31'b0, ld_valid && hit});
        check_eq("fwd_mask", {28'b0, ld_fwd_mask}, 32'b0);
        check_eq("fwd_data", ld_fwd_data, 32'b0);
`endif
    endtask

    // One clock: check at the falling edge, then advance the model at the rising edge.
    task automatic cycle();
        logic do_pop;
        logic do_push;
        ent_t e;
        @(negedge clk);
        check_outputs();
        do_pop  = (q.size() != 0) && mem_ack;
        do_push = st_valid && (q.size() < DEPTH) && (st_byteen != 4'b0000);
        e.addr  = {st_addr[31:2], 2'b00};
        e.be    = st_byteen;
        e.data  = st_wdata;
        @(posedge clk);
        if (do_pop) void'(q.pop_front());
        if (do_push) q.push_back(e);
        #1;
    endtask

    task automatic drive_store(input logic [31:0] a, input logic [3:0] be, input logic [31:0] d);
        st_valid  = 1'b1;
        st_addr   = a;
        st_byteen = be;
        st_wdata  = d;
    endtask

    initial begin
        err_cnt   = 0;
        chk_cnt   = 0;
        reset     = 1'b1;
        st_valid  = 1'b0;
        st_addr   = 32'b0;
        st_byteen = 4'b0000;
        st_wdata  = 32'b0;
        ld_valid  = 1'b0;
        ld_addr   = 32'b0;
        mem_ack   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_mem_req", {31'b0, mem_req}, 32'd0);
        check_eq("rst_empty", {31'b0, empty}, 32'd1);
        check_eq("rst_mem_addr", mem_addr, 32'h0);
        check_eq("rst_mem_byteen", {28'b0, mem_byteen}, 32'h0);
        check_eq("rst_mem_wdata", mem_wdata, 32'h0);
        check_eq("rst_fwd_mask", {28'b0, ld_fwd_mask}, 32'h0);
        reset = 1'b0;

        // Single store with ack held high: one-cycle request then empty.
        mem_ack = 1'b1;
        drive_store(32'h0000_0100, 4'b0011, 32'h0000_BEEF);
        cycle();
        st_valid = 1'b0;
        #1;
        check_eq("t1_req", {31'b0, mem_req}, 32'd1);
        check_eq("t1_addr", mem_addr, 32'h0000_0100);
        check_eq("t1_be", {28'b0, mem_byteen}, 32'h3);
        check_eq("t1_data", mem_wdata, 32'h0000_BEEF);
        cycle();
        check_eq("t1_req_drop", {31'b0, mem_req}, 32'd0);
        check_eq("t1_empty", {31'b0, empty}, 32'd1);

        // Fill to DEPTH, fifth store stalls, then push blocked on the popping cycle.
        mem_ack = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            drive_store(32'h0000_0400 + 32'(4 * i), 4'b1111, 32'hA000_0000 + 32'(i));
            cycle();
        end
        drive_store(32'h0000_0500, 4'b1100, 32'h5555_0000);
        #1;
        check_eq("full_stall", {31'b0, st_stall}, 32'd1);
        cycle();
        mem_ack = 1'b1;
        cycle();
        check_eq("pop_full_stall_drop", {31'b0, st_stall}, 32'd0);
        check_eq("pop_full_next_addr", mem_addr, 32'h0000_0404);
        cycle();
        st_valid = 1'b0;
        for (int i = 0; i < DEPTH + 1; i++) cycle();
        check_eq("drain_empty", {31'b0, empty}, 32'd1);

        // Load hazard against a pending store to 0x200.
        mem_ack = 1'b0;
        drive_store(32'h0000_0200, 4'b1111, 32'hCAFE_F00D);
        cycle();
        st_valid = 1'b0;
        ld_valid = 1'b1;
        ld_addr  = 32'h0000_0202;
        #1;
`ifdef WB_FORWARD_EN
        check_eq("ld_hit_stall", {31'b0, ld_stall}, 32'd0);
        check_eq("ld_hit_mask", {28'b0, ld_fwd_mask}, 32'hF);
`else
        check_eq("ld_hit_stall", {31'b0, ld_stall}, 32'd1);
`endif
        ld_addr = 32'h0000_0204;
        #1;
        check_eq("ld_miss_stall", {31'b0, ld_stall}, 32'd0);
        mem_ack = 1'b1;
        cycle();
        ld_addr = 32'h0000_0202;
        #1;
        check_eq("ld_after_drain", {31'b0, ld_stall}, 32'd0);

        // Two stores to one word: newest supplies each lane.
        mem_ack  = 1'b0;
        ld_valid = 1'b0;
        drive_store(32'h0000_0300, 4'b0001, 32'h0000_00AA);
        cycle();
        drive_store(32'h0000_0300, 4'b0011, 32'h0000_1122);
        cycle();
        st_valid = 1'b0;
        ld_valid = 1'b1;
        ld_addr  = 32'h0000_0300;
        #1;
`ifdef WB_FORWARD_EN
        check_eq("fwd_mask_newest", {28'b0, ld_fwd_mask}, 32'h3);
        check_eq("fwd_data_newest", ld_fwd_data, 32'h0000_1122);
        check_eq("fwd_no_stall", {31'b0, ld_stall}, 32'd0);
`else
        check_eq("nofwd_stall", {31'b0, ld_stall}, 32'd1);
        check_eq("nofwd_mask", {28'b0, ld_fwd_mask}, 32'h0);
`endif
        cycle();

        // Reset with entries pending discards them at once.
        drive_store(32'h0000_0600, 4'b1111, 32'h1234_5678);
        cycle();
        st_valid = 1'b0;
        ld_addr  = 32'h0000_0600;
        #2;
        reset = 1'b1;
        #1;
        q.delete();
        check_eq("rst_mid_req", {31'b0, mem_req}, 32'd0);
        check_eq("rst_mid_empty", {31'b0, empty}, 32'd1);
        check_eq("rst_mid_ld_stall", {31'b0, ld_stall}, 32'd0);
        @(posedge clk);
        #1;
        reset   = 1'b0;
        mem_ack = 1'b1;
        for (int i = 0; i < 4; i++) cycle();

        // Randomized traffic over a small address window to provoke matches.
        for (int i = 0; i < 600; i++) begin
            st_valid  = ($urandom_range(0, 1) == 1);
            st_addr   = 32'h0000_1000 + 32'($urandom_range(0, 31));
            st_byteen = 4'($urandom_range(0, 15));
            st_wdata  = $urandom;
            mem_ack   = ($urandom_range(0, 2) == 0);
            ld_valid  = ($urandom_range(0, 1) == 1);
            ld_addr   = 32'h0000_1000 + 32'($urandom_range(0, 31));
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/dm_store_buffer.md
# dm_store_buffer

Posted-write buffer between the store-alignment stage (byte enables and lane-shifted write data) and the data memory bus. Accepts aligned store requests from the MEM stage, queues them in a small circular FIFO, and drains them one at a time to memory over a req/ack handshake. The MEM stage never waits on memory latency for stores. Loads are checked against pending entries so that no stale data is read: the load either stalls or takes forwarded bytes, depending on configuration.

## Interface
- DEPTH, 4, number of entries; power of two, ≥2

- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high; clears all state
- st_valid  in  1  store request from MEM stage
- st_addr  in  32  store byte address; bits [1:0] ignored
- st_byteen  in  4  lane enables from store-alignment stage
- st_wdata  in  32  lane-aligned write data
- st_stall  out  1  buffer full; store not accepted this cycle
- ld_valid  in  1  load lookup request
- ld_addr  in  32  load byte address; bits [1:0] ignored
- ld_stall  out  1  load must wait (see Operation)
- ld_fwd_mask  out  4  forwarded-byte mask (only with WB_FORWARD_EN, else tied 0)
- ld_fwd_data  out  32  forwarded bytes, lane-aligned (only with WB_FORWARD_EN, else tied 0)
- mem_req  out  1  head entry valid, write request to memory
- mem_addr  out  32  head word address, {addr[31:2],2'b00}
- mem_byteen  out  4  head lane enables
- mem_wdata  out  32  head write data
- mem_ack  in  1  memory accepted the head write
- empty  out  1  no pending entries

## Operation
- Storage: DEPTH entries {addr[31:2], byteen, wdata}. rd_ptr, wr_ptr (log2 DEPTH bits, wrap modulo DEPTH), count (log2 DEPTH + 1 bits).
- full = (count == DEPTH). st_stall = st_valid & full. It depends on registered count only and does not depend on mem_ack.
- Push: st_valid & ~full & (st_byteen != 0). Write entry at wr_ptr, then wr_ptr+1.
- A request with st_valid and st_byteen == 0 is dropped silently. It does not stall and does not push.
- Pop: mem_req & mem_ack. Then rd_ptr+1.
- Push and pop in the same cycle: count is unchanged and both pointers advance. This is legal at any count < DEPTH. At full, push is blocked even if the pop occurs.
- mem_req = (count != 0). mem_addr, mem_byteen and mem_wdata come directly from entry[rd_ptr]. They are stable while mem_req is high and ack is low.
- No combining: each accepted store produces exactly one memory write, in acceptance order.
- Load check: match_i = entry i valid & (entry.addr == ld_addr[31:2]).
  - Uses registered entries only. A store pushed in the same cycle is not visible to the check. The pipeline guarantees no same-cycle store and load to the same word.
  - An entry being popped this cycle still counts as a match.
- Without WB_FORWARD_EN: ld_stall = ld_valid & (any match_i).
- With WB_FORWARD_EN: see Configuration.
- empty = (count == 0).

## Timing
- Reset values: count=0, rd_ptr=0, wr_ptr=0, mem_req=0, empty=1, st_stall=0, ld_stall=0, ld_fwd_mask=0.
  - Entry contents are don't-care. mem_addr, mem_byteen and mem_wdata are 0 after reset.
- Store accepted at edge N gives mem_req=1 from cycle N+1 (1-cycle latency when the buffer was empty).
- The entry leaves the buffer at the edge where mem_req & mem_ack is sampled. The next entry is presented in the following cycle.
- mem_ack while mem_req=0 is ignored.
- ld_stall and the ld_fwd_* outputs are combinational from ld_addr and registered state.
- Reset mid-drain: all pending entries are discarded immediately. mem_req drops asynchronously.

## Configuration
- WB_FORWARD_EN defined: per byte lane b, the newest matching entry (closest to wr_ptr) with byteen[b]=1 supplies ld_fwd_data[8b+7:8b] and sets ld_fwd_mask[b].
  - ld_stall = 0.
  - The consumer overlays the forwarded lanes onto memory read data.
- WB_FORWARD_EN undefined: ld_fwd_mask and ld_fwd_data are constant 0, the forwarding logic is absent, and ld_stall behaves as described in Operation.

## Test plan
- Reset, then one store addr=0x100, byteen=0011, wdata=0x0000BEEF, with mem_ack held 1.
  - Expect mem_req high for exactly one cycle with mem_addr=0x100, byteen=0011, wdata=0x0000BEEF.
  - Then empty=1.
- Push 4 stores with mem_ack=0. Then: count=4, st_stall=1, and a 5th store is not accepted. Raise mem_ack: the writes drain in push order and st_stall drops the cycle after the first pop.
- Full buffer, st_valid and mem_ack both high. The push is blocked and the pop occurs, so count=3. The next cycle the push is accepted.
- Without WB_FORWARD_EN, with a pending store to 0x200:
  - ld_addr=0x202 gives ld_stall=1.
  - ld_addr=0x204 gives ld_stall=0.
  - After drain, ld_addr=0x202 gives ld_stall=0.
- With WB_FORWARD_EN, pending store 0x300/0001/0x000000AA, then a newer 0x300/0011/0x00001122:
  - Load 0x300 gives ld_fwd_mask=0011, ld_fwd_data=0x00001122, ld_stall=0.
- Assert reset with 3 entries pending. Then mem_req=0 and empty=1 immediately, and no write is issued after reset deasserts.
